// File: rtl/div_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, handshake levels and
// the ALU op codes that select DIV/DIVU.
package div_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    S_FREE   = 2'b00,
    S_BYZERO = 2'b01,
    S_ON     = 2'b10,
    S_END    = 2'b11
  } div_state_e;

  localparam logic DIV_START     = 1'b1;
  localparam logic DIV_STOP      = 1'b0;
  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;

  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift {rem,quo} left by one, trial-subtract the
// divisor and keep the difference when it does not borrow.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quo
);

  logic [DATA_W:0] w_rem_sh;
  logic [DATA_W:0] w_trial;
  logic            w_borrow;

  assign w_rem_sh = {i_rem, i_quo[DATA_W-1]};
  assign w_trial  = w_rem_sh - {1'b0, i_divisor};
  // rem < divisor always holds, so the top bit of the trial is exactly the borrow.
  assign w_borrow = w_trial[DATA_W];

  assign o_rem = w_borrow ? w_rem_sh[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign o_quo = {i_quo[DATA_W-2:0], ~w_borrow};

endmodule

// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU. EX holds i_start until it has
// consumed o_result; i_annul cancels an operation still in flight.
module div
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_signed,
  input  logic [DATA_W-1:0]     i_dividend,
  input  logic [DATA_W-1:0]     i_divisor,
  input  logic                  i_start,
  input  logic                  i_annul,
  output logic [2*DATA_W-1:0]   o_result,
  output logic                  o_ready
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic [DATA_W-1:0]   w_dividend_abs;
  logic [DATA_W-1:0]   w_divisor_abs;
  logic [DATA_W-1:0]   w_rem_nxt;
  logic [DATA_W-1:0]   w_quo_nxt;
  logic [DATA_W-1:0]   w_rem_fix;
  logic [DATA_W-1:0]   w_quo_fix;
  logic                w_last_step;

  // The most negative value negates to itself and is then read as unsigned.
  assign w_dividend_abs = (i_signed && i_dividend[DATA_W-1]) ? -i_dividend : i_dividend;
  assign w_divisor_abs  = (i_signed && i_divisor[DATA_W-1])  ? -i_divisor  : i_divisor;

  div_step #(.DATA_W(DATA_W)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  assign w_rem_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_quo_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_last_step = (r_cnt == CNT_W'(DATA_W - 1));

  // NOTE: every register here, datapath included, is cleared by the synchronous
  // reset so an aborted operation can never leak a partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FREE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_NOT_READY;
    end else begin
      case (r_state)
        S_FREE: begin
          r_result <= '0;
          r_ready  <= DIV_NOT_READY;
          if (i_start == DIV_START && !i_annul) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_dividend_abs;
            r_divisor <= w_divisor_abs;
            r_neg_q   <= i_signed & (i_dividend[DATA_W-1] ^ i_divisor[DATA_W-1]);
            r_neg_r   <= i_signed & i_dividend[DATA_W-1];
            r_state   <= (i_divisor == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          if (i_annul) begin
            r_state <= S_FREE;
          end else begin
            r_result <= '0;
            r_ready  <= DIV_READY;
            r_state  <= S_END;
          end
        end
        S_ON: begin
          if (i_annul) begin
            r_state <= S_FREE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            // The final step and the sign fixup share one edge to meet the latency.
            if (w_last_step) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= DIV_READY;
              r_state  <= S_END;
            end
          end
        end
        S_END: begin
          if (i_start == DIV_STOP) begin
            r_result <= '0;
            r_ready  <= DIV_NOT_READY;
            r_state  <= S_FREE;
          end
        end
        default: r_state <= S_FREE;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_ready  = r_ready;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the restoring divider: latency, signed
// fixup, divide-by-zero, annul, mid-operation reset and handshake exit.
module tb_div;

  logic        clk;
  logic        rst;
  logic        i_signed;
  logic [31:0] i_dividend;
  logic [31:0] i_divisor;
  logic        i_start;
  logic        i_annul;
  logic [63:0] o_result;
  logic        o_ready;

  int n_checks = 0;
  int n_errors = 0;

  div #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_signed   (i_signed),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_start    (i_start),
    .i_annul    (i_annul),
    .o_result   (o_result),
    .o_ready    (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request, count edges to o_ready, check the held result and the exit.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int lat;
    i_signed   = sgn;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (i == 0) begin
        // Operands may change once sampled.
        i_dividend = ~a;
        i_divisor  = ~b;
        i_signed   = ~sgn;
      end
      if (o_ready) break;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, o_result, exp_res);
    for (int i = 0; i < 3; i++) tick();
    check({tag, "_hold_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_hold_result"}, o_result, exp_res);
    i_start = 1'b0;
    tick();
    check({tag, "_exit_ready"}, 64'(o_ready), 64'd0);
    check({tag, "_exit_result"}, o_result, 64'd0);
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    i_signed   = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    i_start    = 1'b0;
    i_annul    = 1'b0;
    tick();
    tick();
    check("reset_ready", 64'(o_ready), 64'd0);
    check("reset_result", o_result, 64'd0);
    rst = 1'b0;
    tick();

    run_op("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
    run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_op("sdiv_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33);
    run_op("div_by_zero", 1'b0, 32'h1234, 32'h0, 64'd0, 2);

    // Annul at step 10: no result may ever appear.
    i_signed = 1'b0; i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check("annul_pre_ready", 64'(o_ready), 64'd0);
    i_annul = 1'b1;
    tick();
    i_annul = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_ready) break;
    end
    check("annul_ready", 64'(o_ready), 64'd0);
    check("annul_result", o_result, 64'd0);
    run_op("udiv_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

    // Start and annul together are never accepted.
    i_dividend = 32'd50; i_divisor = 32'd5; i_start = 1'b1; i_annul = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check("start_annul_ready", 64'(o_ready), 64'd0);
    i_start = 1'b0; i_annul = 1'b0;
    tick();

    // Reset at step 20 aborts the operation.
    i_signed = 1'b0; i_dividend = 32'd1000; i_divisor = 32'd3; i_start = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_ready", 64'(o_ready), 64'd0);
    check("midrst_result", o_result, 64'd0);
    rst = 1'b0;
    i_start = 1'b0;
    tick();
    run_op("udiv_ffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33);

    run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    run_op("udiv_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
